// File: rtl/dispatch_pkg.sv
// Shared defaults and port encodings for the one-to-two dispatch stage.
package dispatch_pkg;

   localparam int unsigned WIDTH_DEFAULT = 32;
   localparam int unsigned CNT_W_DEFAULT = 16;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dispatch_slot.sv
// One-entry valid/ready output slot with a delivered-word counter.
module dispatch_slot
   import dispatch_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             ready_o,
   output logic             valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drain;

   assign drain   = valid_q && out_ready_i;
   assign ready_o = !valid_q || out_ready_i;

   // A load in the same edge as a drain keeps the slot full with the new word.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (drain) begin
         valid_d = 1'b0;
         cnt_d   = cnt_q + CNT_W'(1);
      end
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/dispatch_demux.sv
// Routes a single valid/ready word stream into one of two registered output slots.
module dispatch_demux
   import dispatch_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic ready0, ready1;
   logic load0, load1;
   logic accept;

   // in_ready looks only at the selected slot; the other slot never blocks.
   assign in_ready = (in_sel == PORT1) ? ready1 : ready0;
   assign accept   = in_valid && in_ready;
   assign load0    = accept && (in_sel == PORT0);
   assign load1    = accept && (in_sel == PORT1);

   dispatch_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot0 (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (load0),
      .data_i      (in_data),
      .ready_o     (ready0),
      .valid_o     (out0_valid),
      .out_ready_i (out0_ready),
      .data_o      (out0_data),
      .cnt_o       (cnt0)
   );

   dispatch_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot1 (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (load1),
      .data_i      (in_data),
      .ready_o     (ready1),
      .valid_o     (out1_valid),
      .out_ready_i (out1_ready),
      .data_o      (out1_data),
      .cnt_o       (cnt1)
   );

endmodule

// File: tb/tb_dispatch_demux.sv
// Scoreboard bench for dispatch_demux; a narrow-counter twin shares the stimulus.
module tb_dispatch_demux;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_sel;
   logic        out0_valid, out1_valid;
   logic        out0_ready, out1_ready;
   logic [31:0] out0_data, out1_data;
   logic [15:0] cnt0, cnt1;

   logic        w_in_ready;
   logic        w_out0_valid, w_out1_valid;
   logic [31:0] w_out0_data, w_out1_data;
   logic [3:0]  w_cnt0, w_cnt1;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];

   always #5 clk = ~clk;

   dispatch_demux dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   dispatch_demux #(.WIDTH(32), .CNT_W(4)) dut_w (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (w_in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out0_valid (w_out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (w_out0_data),
      .out1_valid (w_out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (w_out1_data),
      .cnt0       (w_cnt0),
      .cnt1       (w_cnt1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic sel, input logic [31:0] data);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      if (sel) q1.push_back(data);
      else     q0.push_back(data);
   endtask

   // Monitor: every handshake about to complete at the next edge pops its expected word.
   always @(negedge clk) begin
      if (!rst) begin
         if (out0_valid && out0_ready) begin
            if (q0.size() == 0) check("port0_unexpected_word", out0_data, 64'hFFFF_FFFF_FFFF_FFFF);
            else                check("port0_data", out0_data, q0.pop_front());
         end
         if (out1_valid && out1_ready) begin
            if (q1.size() == 0) check("port1_unexpected_word", out1_data, 64'hFFFF_FFFF_FFFF_FFFF);
            else                check("port1_data", out1_data, q1.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      in_sel     = 1'b0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;

      // Reset then idle
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_out0_valid", out0_valid, 0);
      check("rst_out1_valid", out1_valid, 0);
      check("rst_out0_data", out0_data, 0);
      check("rst_out1_data", out1_data, 0);
      check("rst_cnt0", cnt0, 0);
      check("rst_cnt1", cnt1, 0);
      in_sel = 1'b0;
      #1 check("rst_in_ready_sel0", in_ready, 1);
      in_sel = 1'b1;
      #1 check("rst_in_ready_sel1", in_ready, 1);

      // Single route to port 1
      step();
      out1_ready = 1'b1;
      present(1'b1, 32'hDEAD_BEEF);
      step();
      in_valid = 1'b0;
      check("single_out1_valid", out1_valid, 1);
      check("single_out1_data", out1_data, 32'hDEAD_BEEF);
      check("single_out0_valid", out0_valid, 0);
      step();
      check("single_out1_valid_after", out1_valid, 0);
      check("single_cnt1", cnt1, 1);

      // Backpressure on port 0, port 1 unaffected
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      present(1'b0, 32'h11);
      step();
      present(1'b0, 32'h22);
      #1 check("bp_in_ready_blocked", in_ready, 0);
      step();
      check("bp_out0_data_held", out0_data, 32'h11);
      check("bp_out0_valid_held", out0_valid, 1);
      present(1'b1, 32'h33);
      #1 check("bp_in_ready_port1", in_ready, 1);
      step();
      check("bp_out1_data", out1_data, 32'h33);
      check("bp_out0_data_still", out0_data, 32'h11);
      in_valid   = 1'b1;
      in_sel     = 1'b0;
      in_data    = 32'h22;
      out0_ready = 1'b1;
      #1 check("bp_in_ready_release", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("bp_out0_data_new", out0_data, 32'h22);
      check("bp_out0_valid_new", out0_valid, 1);
      check("bp_cnt0", cnt0, 1);
      out1_ready = 1'b1;
      step();
      check("bp_cnt0_final", cnt0, 2);
      check("bp_cnt1_final", cnt1, 2);
      check("bp_out0_valid_empty", out0_valid, 0);

      // Streaming 1..8 alternating ports
      for (int i = 1; i <= 8; i++) begin
         present((i % 2) == 0, 32'(i));
         #1 check("stream_in_ready", in_ready, 1);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      check("stream_cnt0", cnt0, 6);
      check("stream_cnt1", cnt1, 6);
      check("stream_q0_drained", q0.size(), 0);
      check("stream_q1_drained", q1.size(), 0);

      // Reset mid-operation with both slots full
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      present(1'b0, 32'hA);
      step();
      present(1'b1, 32'hB);
      step();
      in_valid = 1'b0;
      check("midrst_out0_full", out0_valid, 1);
      check("midrst_out1_full", out1_valid, 1);
      #2;
      rst = 1'b1;
      q0.delete();
      q1.delete();
      #1;
      check("midrst_out0_valid_drop", out0_valid, 0);
      check("midrst_out1_valid_drop", out1_valid, 0);
      check("midrst_cnt0", cnt0, 0);
      step();
      rst = 1'b0;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      step();
      step();
      check("midrst_cnt0_after", cnt0, 0);
      check("midrst_cnt1_after", cnt1, 0);
      check("midrst_out0_idle", out0_valid, 0);

      // Counter wrap on the 4-bit twin: 17 words on port 0
      for (int i = 0; i < 17; i++) begin
         present(1'b0, 32'(100 + i));
         step();
         check("wrap_cnt0_seq", w_cnt0, i % 16);
      end
      in_valid = 1'b0;
      step();
      check("wrap_cnt0_final_w4", w_cnt0, 1);
      check("wrap_cnt0_final_w16", cnt0, 17);
      check("wrap_cnt1_untouched", w_cnt1, 0);

      step();
      check("end_q0_empty", q0.size(), 0);
      check("end_q1_empty", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/dispatch_demux.md
Name: dispatch_demux

Overview:
- One-to-two routing stage for the datapath: the complement of the 2:1 select mux.
- Takes a single valid/ready word stream and steers each word, per its select bit, into one of two registered output slots.
- Each output slot is its own valid/ready stream.
- Sits between a single producer (decode/ALU result) and two consumers (e.g. writeback vs. store path). Provides one register stage and backpressure per destination.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 16, width of the per-port delivered-word counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  stage accepts the word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  destination: 0 = port 0, 1 = port 1. Sampled only when in_valid=1.
- out0_valid  output  1  slot 0 holds a word.
- out0_ready  input  1  consumer 0 takes the word.
- out0_data  output  WIDTH  slot 0 word.
- out1_valid  output  1  slot 1 holds a word.
- out1_ready  input  1  consumer 1 takes the word.
- out1_data  output  WIDTH  slot 1 word.
- cnt0  output  CNT_W  words delivered on port 0.
- cnt1  output  CNT_W  words delivered on port 1.

Behaviour:
- Reset, asynchronous, active-high: out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0. Slot contents are discarded, including on reset mid-transfer. After rst deasserts, the first accept may occur on the next clk edge.
- Each slot is a one-entry buffer with state EMPTY/FULL. outN_valid = FULL.
- in_ready is combinational: in_ready = !outS_valid || outS_ready, where S = in_sel. It depends only on the selected slot; the other slot's state never blocks.
- Accept: in_valid && in_ready at a rising edge loads in_data into slot S and sets it FULL. Latency is 1 cycle (word visible on outS_data the cycle after acceptance).
- Drain: outN_valid && outN_ready at an edge delivers the word. Slot goes EMPTY unless it is reloaded in the same edge.
- Simultaneous drain and load on the same slot: slot stays FULL holding the new word. Full throughput is 1 word/cycle per port.
- Both slots may drain in the same cycle. Only one load per cycle, since there is a single input.
- Stability: while outN_valid && !outN_ready, outN_data and outN_valid hold unchanged.
- Ordering: preserved within each port. No ordering guarantee across ports.
- in_sel and in_data are don't-care when in_valid=0. in_ready may still toggle with in_sel; producers must not depend on it.
- Counters: cntN increments by 1 on each port-N drain handshake. It wraps from 2^CNT_W-1 to 0 with no sticky flag.
- Combinational path out*_ready -> in_ready is permitted. There is no path in_valid -> in_ready.
- outN_data is updated only on load, never on drain.

Decomposition:
- Shared package dispatch_pkg holds the WIDTH default, the CNT_W default, and localparams PORT0=1'b0 and PORT1=1'b1.
- Natural sub-module: dispatch_slot, instantiated twice. It holds the one-entry valid/data register, load/drain logic and delivered-word counter, and exposes a slot-level ready (!valid || out_ready).
- Top level does select decode and in_ready muxing.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> out0_valid=out1_valid=0, data=0, cnt0=cnt1=0, in_ready=1 for both in_sel values.
- Single route: in_data=32'hDEADBEEF, in_sel=1, in_valid=1 for one cycle, out1_ready=1 -> next cycle out1_valid=1 with data DEADBEEF and out0_valid=0. Following cycle out1_valid=0 and cnt1=1.
- Backpressure: load 32'h11 to port 0 with out0_ready=0, then present 32'h22 on port 0 -> in_ready=0 and out0_data stays 11. Present 32'h33 to port 1 -> accepted. Raise out0_ready -> 11 delivered, 22 accepted the same edge, out0_data=22 next cycle.
- Streaming: 8 back-to-back words 1..8 alternating sel, both readies=1 -> in_ready constantly 1. Port 0 sees 1,3,5,7; port 1 sees 2,4,6,8; cnt0=cnt1=4.
- Reset mid-operation: both slots FULL (32'hA, 32'hB), both readies=0, assert rst between edges -> out*_valid drop immediately. After release nothing is delivered and counters read 0.
- Counter wrap: CNT_W=4, deliver 17 words on port 0 -> cnt0 sequences ...,15,0,1 and ends at 1.
